// File: rtl/sa_ctrl_pkg.sv
// Shared definitions for the systolic-array tile controller.
// Holds the FSM state encoding and the default array and counter sizes.
package sa_ctrl_pkg;
  localparam int ARRAY_N_DEF = 4;
  localparam int CNT_W_DEF   = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_e;
endpackage

// File: rtl/sa_skew_line.sv
// 1-bit delay line with a tap after every stage.
// o_q[k] is i_d delayed by k+1 cycles.
// Ports:
//   clk, rst (async, active-high)
//   i_clr  synchronous clear of every stage
//   i_d    input bit
//   o_q    tapped outputs, DEPTH bits
module sa_skew_line #(
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_d,
  output logic [DEPTH-1:0] o_q
);
  logic [DEPTH-1:0] r_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh <= '0;
    end else if (i_clr) begin
      r_sh <= '0;
    end else begin
      r_sh[0] <= i_d;
      for (int k = 1; k < DEPTH; k++) r_sh[k] <= r_sh[k-1];
    end
  end

  assign o_q = r_sh;
endmodule

// File: rtl/sa_tile_scheduler.sv
// Tile sequencer for an ARRAY_N x ARRAY_N systolic array.
// A tile has three phases. First it loads ARRAY_N weight rows. Then it
// streams num_vec activation vectors, with skewed per-row injection. Finally
// it drains for 2*ARRAY_N cycles until the last column result leaves the
// array. A one-cycle done pulse follows the drain.
// Ports:
//   clk, rst (async, active-high)
//   start, num_vec     tile request; sampled only in IDLE
//   abort              synchronous return to IDLE; all delay lines cleared
//   w_valid/w_ready    weight-row handshake; weight_en = accepted row
//   a_valid/a_ready    activation handshake; act_row_en[0] = accepted vector
//   act_row_en         per-row injection strobes, row r lags row r-1 by 1 cycle
//   col_valid          per-column result strobes, col c lags row 0 by ARRAY_N+c cycles
//   busy, done, state  status and debug outputs
// ARRAY_N must be at least 2.
module sa_tile_scheduler
  import sa_ctrl_pkg::*;
#(
  parameter int ARRAY_N = ARRAY_N_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_vec,
  input  logic               abort,
  input  logic               w_valid,
  output logic               w_ready,
  output logic               weight_en,
  input  logic               a_valid,
  output logic               a_ready,
  output logic [ARRAY_N-1:0] act_row_en,
  output logic [ARRAY_N-1:0] col_valid,
  output logic               busy,
  output logic               done,
  output logic [2:0]         state
);
  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;      // weight rows in LOAD_W, drain cycles in DRAIN
  logic [CNT_W-1:0] r_vec;
  logic [CNT_W-1:0] r_num_vec;
  logic             r_w_ready;
  logic             r_a_ready;
  logic             r_busy;
  logic             r_done;

  logic               w_act0;
  logic [ARRAY_N-2:0] w_act_taps;

  assign weight_en = w_valid & r_w_ready;
  assign w_act0    = a_valid & r_a_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_vec     <= '0;
      r_num_vec <= '0;
      r_w_ready <= 1'b0;
      r_a_ready <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (abort) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_vec     <= '0;
      r_w_ready <= 1'b0;
      r_a_ready <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_state   <= S_LOAD_W;
          r_num_vec <= num_vec;
          r_cnt     <= '0;
          r_vec     <= '0;
          r_w_ready <= 1'b1;
          r_busy    <= 1'b1;
        end
        S_LOAD_W: if (weight_en) begin
          if (r_cnt == CNT_W'(ARRAY_N - 1)) begin
            r_cnt     <= '0;
            r_w_ready <= 1'b0;
            if (r_num_vec != '0) begin
              r_state   <= S_STREAM;
              r_a_ready <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_STREAM: if (w_act0) begin
          // Compare against num_vec-1 so that num_vec = 2^CNT_W-1 never wraps.
          r_vec <= r_vec + CNT_W'(1);
          if (r_vec == r_num_vec - CNT_W'(1)) begin
            r_state   <= S_DRAIN;
            r_a_ready <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (r_cnt == CNT_W'(2 * ARRAY_N - 1)) begin
            r_cnt   <= '0;
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_w_ready <= 1'b0;
          r_a_ready <= 1'b0;
        end
      endcase
    end
  end

  // Row skew: row r sees the vector r cycles after row 0.
  sa_skew_line #(.DEPTH(ARRAY_N - 1)) u_act_skew (
    .clk   (clk),
    .rst   (rst),
    .i_clr (abort),
    .i_d   (w_act0),
    .o_q   (w_act_taps)
  );

  assign act_row_en = {w_act_taps, w_act0};

  // Column c result appears c+1 cycles after the bottom row is injected.
  sa_skew_line #(.DEPTH(ARRAY_N)) u_col_skew (
    .clk   (clk),
    .rst   (rst),
    .i_clr (abort),
    .i_d   (act_row_en[ARRAY_N-1]),
    .o_q   (col_valid)
  );

  assign w_ready = r_w_ready;
  assign a_ready = r_a_ready;
  assign busy    = r_busy;
  assign done    = r_done;
  assign state   = r_state;
endmodule

// File: tb/tb_sa_tile_scheduler.sv
module tb_sa_tile_scheduler;
  localparam int N  = 4;
  localparam int CW = 8;
  localparam int NT = 300;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] num_vec;
  logic          abort;
  logic          w_valid, w_ready, weight_en;
  logic          a_valid, a_ready;
  logic [N-1:0]  act_row_en, col_valid;
  logic          busy, done;
  logic [2:0]    state;

  sa_tile_scheduler #(.ARRAY_N(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .abort(abort),
    .w_valid(w_valid), .w_ready(w_ready), .weight_en(weight_en),
    .a_valid(a_valid), .a_ready(a_ready), .act_row_en(act_row_en),
    .col_valid(col_valid), .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    int           cyc;
    logic         w;
    logic [N-1:0] a;
    logic [N-1:0] c;
    logic         d;
  } ev_t;
  ev_t q[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  // Monitor: every cycle with any strobe active must match the next expected event.
  logic any_out;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      checks++; fails++;
      $display("FAIL missing_event exp_cyc=%0d now=%0d w=%0b a=%0h c=%0h d=%0b",
               q[0].cyc, cyc, q[0].w, q[0].a, q[0].c, q[0].d);
      void'(q.pop_front());
    end
    any_out = weight_en | (|act_row_en) | (|col_valid) | done;
    if (any_out) begin
      checks++;
      if (q.size() == 0 || q[0].cyc != cyc) begin
        fails++;
        $display("FAIL unexpected_event cyc=%0d got w=%0b a=%0h c=%0h d=%0b",
                 cyc, weight_en, act_row_en, col_valid, done);
      end else begin
        if (q[0].w !== weight_en || q[0].a !== act_row_en ||
            q[0].c !== col_valid || q[0].d !== done) begin
          fails++;
          $display("FAIL event cyc=%0d got w=%0b a=%0h c=%0h d=%0b exp w=%0b a=%0h c=%0h d=%0b",
                   cyc, weight_en, act_row_en, col_valid, done,
                   q[0].w, q[0].a, q[0].c, q[0].d);
        end
        void'(q.pop_front());
      end
    end
  end

  // One tile. t is the cycle offset from the cycle start is presented.
  // Spec timing with w_valid=1: weight_en t=1..4, STREAM entered at t=5,
  // pattern bit k is a_valid at t=5+k, done 9 cycles after the last accept
  // (or t=5 when num_vec=0).
  task automatic run_tile(input int nv, input logic [15:0] pat, input int plen,
                          input bit av_all, input bit hold, input int abort_t,
                          input int rst_t, input string nm);
    logic         ew [NT];
    logic         ed [NT];
    logic [N-1:0] ea [NT];
    logic [N-1:0] ec [NT];
    int s, na, last, td, cut, tend;
    ev_t e;
    s = cyc;
    for (int t = 0; t < NT; t++) begin ew[t] = 0; ed[t] = 0; ea[t] = '0; ec[t] = '0; end
    for (int t = 1; t <= N; t++) ew[t] = 1;
    na = 0; last = -1;
    for (int k = 0; k < NT - 20 && na < nv; k++) begin
      if (av_all || (k < plen && pat[k])) begin
        for (int r = 0; r < N; r++) ea[5+k+r][r] = 1'b1;
        for (int c = 0; c < N; c++) ec[5+k+N+c][c] = 1'b1;
        na++; last = 5 + k;
      end
    end
    td = (nv == 0) ? 5 : last + 9;
    ed[td] = 1;
    cut  = (abort_t >= 0) ? abort_t + 1 : (rst_t >= 0) ? rst_t : NT;
    tend = (abort_t >= 0) ? abort_t + 6 : (rst_t >= 0) ? rst_t + 6 : td + 2;
    for (int t = 0; t < cut && t < NT; t++) begin
      if (ew[t] || ed[t] || ea[t] != '0 || ec[t] != '0) begin
        e.cyc = s + t; e.w = ew[t]; e.a = ea[t]; e.c = ec[t]; e.d = ed[t];
        q.push_back(e);
      end
    end
    num_vec = nv[CW-1:0];
    for (int t = 0; t <= tend; t++) begin
      start   = (t == 0) || (hold && t <= td);
      abort   = (t == abort_t);
      a_valid = av_all ? 1'b1 : (t >= 5 && t - 5 < plen) ? pat[t-5] : 1'b0;
      if (rst_t >= 0 && t == rst_t) begin
        rst = 1'b1;
        #1;
        chk({nm, "_rst_act"}, act_row_en, 0);
        chk({nm, "_rst_col"}, col_valid, 0);
        chk({nm, "_rst_busy"}, busy, 0);
        chk({nm, "_rst_state"}, state, 0);
        chk({nm, "_rst_ready"}, {a_ready, w_ready, weight_en, done}, 0);
      end else if (rst_t >= 0 && t == rst_t + 1) begin
        rst = 1'b0;
      end
      if (t == 1) chk({nm, "_busy_w_ready"}, {busy, w_ready}, 2'b11);
      if (cut == NT && t == td) chk({nm, "_state_done"}, state, 4);
      if (cut == NT && nv > 0 && t == last + 1) chk({nm, "_a_ready_drain"}, a_ready, 0);
      if (abort_t >= 0 && t == abort_t + 1) chk({nm, "_abort_idle"}, {busy, state}, 0);
      @(posedge clk); #1;
    end
    start = 0; abort = 0; a_valid = 0;
    chk({nm, "_queue_empty"}, q.size(), 0);
    chk({nm, "_end_idle"}, {busy, state}, 0);
  endtask

  initial begin
    rst = 1'b1; start = 0; abort = 0; w_valid = 0; a_valid = 0; num_vec = '0;
    #3;
    chk("reset_outputs", {weight_en, w_ready, a_ready, act_row_en, col_valid, busy, done}, 0);
    chk("reset_state", state, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    w_valid = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", {busy, state, w_ready, a_ready}, 0);

    run_tile(3,   16'h0,  0, 1, 0, -1, -1, "basic_nv3");
    run_tile(0,   16'h0,  0, 1, 0, -1, -1, "nv0");
    run_tile(3,   16'h15, 5, 0, 0, -1, -1, "bubbles");
    run_tile(3,   16'h3,  2, 0, 0,  7, -1, "abort");
    run_tile(2,   16'h0,  0, 1, 0, -1, -1, "after_abort");
    run_tile(3,   16'h0,  0, 1, 0, -1, 10, "rst_drain");
    run_tile(1,   16'h0,  0, 1, 0, -1, -1, "after_rst");
    run_tile(2,   16'h0,  0, 1, 1, -1, -1, "start_held");
    run_tile(255, 16'h0,  0, 1, 0, -1, -1, "nv_max");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
